// File: rtl/prime_pkg.sv
// Shared types and constants for the prime range scanner and its output FIFO.
package prime_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam int WIDTH_DEF      = 32;
  localparam int FIFO_DEPTH_DEF = 4;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int FIFO_PTR_W_DEF = ptr_width(FIFO_DEPTH_DEF);

endpackage

// File: rtl/prime_fifo.sv
// Synchronous FIFO buffering found primes; head_data reads 0 while empty.
// Full is a plain occupancy flag, so a push while full is refused even if a pop happens.
module prime_fifo
  import prime_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/prime_range_scanner.sv
// Sweeps [range_lo, range_hi] through an external prime checker and streams the primes out.
// Define PRIME_SCAN_SKIP_EVEN_EN to skip even candidates above 2.
module prime_range_scanner
  import prime_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] range_lo,
  input  logic [WIDTH-1:0] range_hi,
  output logic [WIDTH-1:0] chk_number,
  input  logic             chk_is_prime,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prime_count
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] hi_q;
  logic             start_ok;
  logic [WIDTH:0]   first_cand;
  logic             empty_range;
  logic [WIDTH:0]   next_cand;
  logic             last;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             consume;

  assign start_ok = start && (state == IDLE || state == DONE);

  // Candidate arithmetic is one bit wider so the end test never sees a wrap.
`ifdef PRIME_SCAN_SKIP_EVEN_EN
  assign first_cand = (!range_lo[0] && range_lo > WIDTH'(2)) ? {1'b0, range_lo} + (WIDTH+1)'(1)
                                                              : {1'b0, range_lo};
  assign next_cand  = (chk_number < WIDTH'(3)) ? {1'b0, chk_number} + (WIDTH+1)'(1)
                                               : {1'b0, chk_number} + (WIDTH+1)'(2);
`else
  assign first_cand = {1'b0, range_lo};
  assign next_cand  = {1'b0, chk_number} + (WIDTH+1)'(1);
`endif

  assign empty_range = first_cand > {1'b0, range_hi};
  assign last        = next_cand > {1'b0, hi_q};
  assign push        = (state == SCAN) && chk_is_prime && !fifo_full;
  assign consume     = (state == SCAN) && (!chk_is_prime || !fifo_full);
  assign out_valid   = !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_ok) state_nxt = !empty_range ? SCAN : (fifo_empty ? DONE : DRAIN);
      SCAN:       if (consume && last) state_nxt = DRAIN;
      DRAIN:      if (fifo_empty) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SCAN) || (state == DRAIN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_number  <= '0;
      hi_q        <= '0;
      prime_count <= '0;
    end else if (start_ok) begin
      chk_number  <= first_cand[WIDTH-1:0];
      hi_q        <= range_hi;
      prime_count <= '0;
    end else begin
      if (consume && !last) chk_number <= next_cand[WIDTH-1:0];
      if (push) prime_count <= prime_count + 1'b1;
    end
  end

  prime_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (chk_number),
    .full      (fifo_full),
    .pop       (out_ready),
    .empty     (fifo_empty),
    .head_data (out_data)
  );

endmodule

// File: tb/tb_prime_range_scanner.sv
// Bench for prime_range_scanner: directed ranges plus random ranges and back-pressure,
// checked against a trial-division reference of the primes in each range.
module tb_prime_range_scanner;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] range_lo;
  logic [W-1:0] range_hi;
  logic [W-1:0] chk_number;
  logic         chk_is_prime;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         busy;
  logic         done;
  logic [W-1:0] prime_count;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  prime_range_scanner #(.WIDTH(W), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .range_lo     (range_lo),
    .range_hi     (range_hi),
    .chk_number   (chk_number),
    .chk_is_prime (chk_is_prime),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .prime_count  (prime_count)
  );

  function automatic logic is_prime_f(input logic [W-1:0] n);
    longint unsigned v;
    v = longint'(n);
    if (v < 2) return 1'b0;
    for (longint unsigned d = 2; d * d <= v; d++)
      if (v % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Stand-in for the combinational checker that sits downstream of chk_number.
  always_comb chk_is_prime = is_prime_f(chk_number);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: whenever a prime is offered it must be the oldest outstanding one.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {32'd0, out_data}, 64'd0);
      end else begin
        check("out_data", out_data, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic model_build(input logic [W-1:0] lo, input logic [W-1:0] hi,
                             output int cnt, output int ncand, output bit last_prime);
    bit cand;
    cnt = 0; ncand = 0; last_prime = 1'b0;
    for (longint unsigned x = longint'(lo); x <= longint'(hi); x++) begin
`ifdef PRIME_SCAN_SKIP_EVEN_EN
      cand = (x <= 3) || (x % 2 == 1);
`else
      cand = 1'b1;
`endif
      if (cand) begin
        ncand++;
        last_prime = is_prime_f(W'(x));
        if (last_prime) begin
          cnt++;
          exp_q.push_back(W'(x));
        end
      end
    end
  endtask

  task automatic drive_ready(input int mode, input int cyc, input int hold);
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = (cyc >= hold);
    endcase
  endtask

  // mode 0: always ready, 1: random ready, 2: held off for 'hold' cycles then ready.
  task automatic run_scan(input logic [W-1:0] lo, input logic [W-1:0] hi, input int mode,
                          input int hold, input logic [W-1:0] stall_exp,
                          input bit chk_busy, input bit chk_wrap);
    int cnt, ncand, busy_cnt, exp_busy, cyc;
    bit last_prime, got_done;
    model_build(lo, hi, cnt, ncand, last_prime);
    exp_busy = (ncand == 0) ? 0 : ncand + 1 + int'(last_prime);
    @(posedge clk); #1;
    range_lo = lo; range_hi = hi; start = 1'b1;
    drive_ready(mode, 0, hold);
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = 0; cyc = 0; got_done = 1'b0;
    while (cyc < 3000 && !got_done) begin
      @(negedge clk);
      if (mode == 2 && cyc == hold) begin
        check("stall_candidate", chk_number, stall_exp);
        check("stall_busy", busy, 1);
      end
      if (done) got_done = 1'b1;
      else begin
        if (busy) busy_cnt++;
        @(posedge clk); #1;
        cyc++;
        drive_ready(mode, cyc, hold);
      end
    end
    check("done_reached", got_done, 1);
    check("prime_count", prime_count, cnt);
    check("busy_at_done", busy, 0);
    check("out_valid_at_done", out_valid, 0);
    check("undelivered", exp_q.size(), 0);
    if (chk_busy) check("busy_cycles", busy_cnt, exp_busy);
    if (hi < lo) check("fast_done", cyc <= 2, 1);
    if (chk_wrap) check("no_wrap_chk_number", chk_number, hi);
    exp_q.delete();
  endtask

  initial begin
    int cnt, ncand;
    bit lp;
    logic [W-1:0] lo, hi;

    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    range_lo = '0; range_hi = '0;
    #12;
    check("rst_chk_number", chk_number, 0);
    check("rst_prime_count", prime_count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_scan(32'd2, 32'd20, 0, 0, '0, 1'b1, 1'b0);
    run_scan(32'd0, 32'd1, 0, 0, '0, 1'b1, 1'b0);
    run_scan(32'd10, 32'd5, 0, 0, '0, 1'b1, 1'b0);
    run_scan(32'd2, 32'd30, 2, 40, 32'd11, 1'b0, 1'b0);
    run_scan(32'hFFFF_FFFA, 32'hFFFF_FFFF, 0, 0, '0, 1'b1, 1'b1);

    // Reset in the middle of a long scan, then a fresh scan.
    @(posedge clk); #1;
    model_build(32'd2, 32'd100, cnt, ncand, lp);
    range_lo = 32'd2; range_hi = 32'd100; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_chk_number", chk_number, 0);
    check("midrst_prime_count", prime_count, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_scan(32'd50, 32'd60, 0, 0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      lo = W'($urandom_range(0, 300));
      hi = lo + W'($urandom_range(0, 60));
      if ($urandom_range(0, 5) == 0 && lo != 0) hi = lo - 1;
      run_scan(lo, hi, 1, 0, '0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
